// File: rtl/execute_pipe_pkg.sv
// execute_pkg: shared definitions for the execute stage.
//   - op_e       : ALU/branch-unit operation codes (3 bits)
//   - br_cond_e  : conditional-branch test selected by branch_cond
//   - state_e    : execute stage control states
//   - DEFAULT_WIDTH : default datapath width
//   - cond_met() : evaluates a branch condition from zero/sign flags
package execute_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_PASSB = 3'b101,
        OP_LINK  = 3'b110,
        OP_MUL   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        BC_EQZ = 2'b00,   // a == 0
        BC_NEZ = 2'b01,   // a != 0
        BC_LTZ = 2'b10,   // a <  0 (signed)
        BC_GEZ = 2'b11    // a >= 0 (signed)
    } br_cond_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    function automatic logic cond_met(input br_cond_e c,
                                      input logic     is_zero,
                                      input logic     is_neg);
        logic r;
        r = 1'b0;
        case (c)
            BC_EQZ:  r = is_zero;
            BC_NEZ:  r = !is_zero;
            BC_LTZ:  r = is_neg;
            BC_GEZ:  r = !is_neg;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/execute_pipe_if.sv
// execute_pipe_if: operation-in / result-out bus of the execute stage.
//   Issue side : in_valid, in_ready, op, a, b, imm, seq_pc, use_imm,
//                choose_branch, branch_cond, branch_i, branch_j
//   Result side: out_valid, out_ready, result, branch, branch_pc, illegal
//   master: upstream/downstream environment; slave: the execute stage.
interface execute_pipe_if
    import execute_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] seq_pc;
    logic             use_imm;
    logic             choose_branch;
    logic [1:0]       branch_cond;
    logic             branch_i;
    logic             branch_j;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             branch;
    logic [WIDTH-1:0] branch_pc;
    logic             illegal;

    modport master (
        output in_valid, op, a, b, imm, seq_pc, use_imm, choose_branch,
               branch_cond, branch_i, branch_j, out_ready,
        input  in_ready, out_valid, result, branch, branch_pc, illegal
    );

    modport slave (
        input  in_valid, op, a, b, imm, seq_pc, use_imm, choose_branch,
               branch_cond, branch_i, branch_j, out_ready,
        output in_ready, out_valid, result, branch, branch_pc, illegal
    );

endinterface

// File: rtl/execute_pipe_mul_seq.sv
// execute_mul_seq: iterative shift-add multiplier, one partial product per
// clock, WIDTH iterations in total. Returns the low WIDTH bits of the
// unsigned product.
//   clk, rst_n   : clock, async active-low reset
//   start        : load operands (first iteration is done on the load edge)
//   abort        : drop the operation in progress
//   multiplicand, multiplier : operands
//   done         : product valid (held high until the next clock edge)
//   product      : low WIDTH bits of multiplicand*multiplier
module execute_mul_seq
    import execute_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             active_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;

    assign done    = active_q && (count_q == CNT_W'(WIDTH));
    assign product = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (abort) begin
            active_q <= 1'b0;
            count_q  <= '0;
        end else if (start) begin
            // Iteration 1 is folded into the load so the product is ready
            // WIDTH edges after start, leaving one edge for the output register.
            active_q <= 1'b1;
            count_q  <= CNT_W'(1);
            acc_q    <= multiplier[0] ? multiplicand : '0;
            mcand_q  <= multiplicand << 1;
            mplier_q <= multiplier >> 1;
        end else if (done) begin
            active_q <= 1'b0;
            count_q  <= '0;
        end else if (active_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/execute_pipe.sv
// execute_pipe: single-stage execute unit. Computes an ALU result plus the
// branch decision and target, registered one cycle after acceptance. MUL runs
// on an iterative multiplier and blocks the stage until its result retires.
//   clk, rst_n : clock, async active-low reset
//   flush      : kill in-flight and held operation (wins over accept/retire)
//   bus        : execute_pipe_if.slave (issue + result handshakes)
//   busy       : stage is in MUL or HOLD
// Build option: define EXECUTE_PIPE_MUL_EN to build the multiplier. Without
// it, op MUL completes in one cycle with result 0 and illegal set.
module execute_pipe
    import execute_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    execute_pipe_if.slave bus,
    output logic          busy
);

    state_e           state_q, state_d;
    op_e              op_in;
    logic [WIDTH-1:0] b_opnd;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] branch_tgt;
    logic             branch_taken;
    logic             in_ready;
    logic             accept;
    logic             is_mul_op;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic             op_illegal;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             branch_q;
    logic [WIDTH-1:0] branch_pc_q;
    logic             illegal_q;

`ifdef EXECUTE_PIPE_MUL_EN
    localparam bit MUL_BUILT = 1'b1;

    execute_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (mul_start),
        .abort        (flush),
        .multiplicand (bus.a),
        .multiplier   (b_opnd),
        .done         (mul_done),
        .product      (mul_product)
    );
`else
    localparam bit MUL_BUILT = 1'b0;

    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    assign op_in      = op_e'(bus.op);
    assign b_opnd     = bus.use_imm ? bus.imm : bus.b;
    assign in_ready   = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready) && !flush;
    assign accept     = bus.in_valid && in_ready;
    assign is_mul_op  = (op_in == OP_MUL);
    assign mul_start  = accept && is_mul_op && MUL_BUILT;
    assign op_illegal = is_mul_op && !MUL_BUILT;

    assign branch_tgt   = bus.imm + (bus.choose_branch ? bus.a : bus.seq_pc);
    assign branch_taken = (bus.branch_i &&
                           cond_met(br_cond_e'(bus.branch_cond),
                                    bus.a == '0, bus.a[WIDTH-1])) || bus.branch_j;

    always_comb begin
        alu_res = '0;
        case (op_in)
            OP_ADD:   alu_res = bus.a + b_opnd;
            OP_SUB:   alu_res = bus.a - b_opnd;
            OP_AND:   alu_res = bus.a & b_opnd;
            OP_OR:    alu_res = bus.a | b_opnd;
            OP_XOR:   alu_res = bus.a ^ b_opnd;
            OP_PASSB: alu_res = b_opnd;
            OP_LINK:  alu_res = bus.seq_pc;
            default:  alu_res = '0;   // MUL: multiplier result or illegal zero
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (mul_start)     state_d = ST_MUL;
                ST_MUL:  if (mul_done)      state_d = ST_HOLD;
                ST_HOLD: if (bus.out_ready) state_d = ST_IDLE;
                default:                    state_d = ST_IDLE;
            endcase
        end
    end

    // Branch outcome is captured at acceptance for every op, including MUL,
    // so it is already stable when the late MUL result is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            branch_q    <= 1'b0;
            branch_pc_q <= '0;
            illegal_q   <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            branch_q    <= branch_taken;
            branch_pc_q <= branch_tgt;
            illegal_q   <= op_illegal;
            out_valid_q <= !mul_start;
            if (!mul_start) begin
                result_q <= alu_res;
            end
        end else if ((state_q == ST_MUL) && mul_done) begin
            out_valid_q <= 1'b1;
            result_q    <= mul_product;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.branch    = branch_q;
    assign bus.branch_pc = branch_pc_q;
    assign bus.illegal   = illegal_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: scoreboard bench for execute_pipe (WIDTH=16). Directed
// cases followed by random traffic; expected responses come from a
// behavioural model and are checked by an independent monitor.
`timescale 1ns/1ps
module tb_execute_pipe;
    import execute_pkg::*;

    localparam int W = 16;
`ifdef EXECUTE_PIPE_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic flush;
    logic busy;

    execute_pipe_if #(.WIDTH(W)) bus ();

    execute_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] result;
        logic         branch;
        logic [W-1:0] branch_pc;
        logic         illegal;
        bit           is_mul;
        int           due;
        bit           seen;
    } exp_t;

    typedef struct {
        bit           v;
        logic [2:0]   op;
        logic [W-1:0] a, b, imm, pc;
        bit           use_imm, choose;
        logic [1:0]   cond;
        bit           bi, bj;
    } stim_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   flush_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: straight from the operation table.
    function automatic exp_t model(input stim_t s);
        exp_t            e;
        logic [W-1:0]    bb;
        logic [63:0]     prod;
        logic signed [W-1:0] sa;
        bit              c;
        bb   = s.use_imm ? s.imm : s.b;
        sa   = s.a;
        prod = 64'(s.a) * 64'(bb);
        case (s.cond)
            2'd0:    c = (s.a == 0);
            2'd1:    c = (s.a != 0);
            2'd2:    c = (sa < 0);
            default: c = (sa >= 0);
        endcase
        case (s.op)
            3'd0:    e.result = s.a + bb;
            3'd1:    e.result = s.a - bb;
            3'd2:    e.result = s.a & bb;
            3'd3:    e.result = s.a | bb;
            3'd4:    e.result = s.a ^ bb;
            3'd5:    e.result = bb;
            3'd6:    e.result = s.pc;
            default: e.result = MUL_ON ? prod[W-1:0] : '0;
        endcase
        e.branch    = (s.bi && c) || s.bj;
        e.branch_pc = s.imm + (s.choose ? s.a : s.pc);
        e.illegal   = (s.op == 3'd7) && !MUL_ON;
        e.is_mul    = (s.op == 3'd7) && MUL_ON;
        e.due       = 0;
        e.seen      = 1'b0;
        return e;
    endfunction

    function automatic stim_t mk(input logic [2:0] op, input logic [W-1:0] a, b, imm, pc,
                                 input bit use_imm, choose, input logic [1:0] cond,
                                 input bit bi, bj);
        stim_t s;
        s.v = 1'b1; s.op = op; s.a = a; s.b = b; s.imm = imm; s.pc = pc;
        s.use_imm = use_imm; s.choose = choose; s.cond = cond; s.bi = bi; s.bj = bj;
        return s;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s = mk(3'd0, '0, '0, '0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        s.v = 1'b0;
        return s;
    endfunction

    // One clock of stimulus: drive after the edge, check handshake outputs,
    // and push the expected response if the model says the op is accepted.
    task automatic step(input stim_t s, input bit ordy, input bit fl);
        bit   exp_rdy, exp_busy;
        exp_t e;
        @(posedge clk);
        #1;
        if (flush_prev) sb.delete();
        bus.in_valid      = s.v;
        bus.op            = s.op;
        bus.a             = s.a;
        bus.b             = s.b;
        bus.imm           = s.imm;
        bus.seq_pc        = s.pc;
        bus.use_imm       = s.use_imm;
        bus.choose_branch = s.choose;
        bus.branch_cond   = s.cond;
        bus.branch_i      = s.bi;
        bus.branch_j      = s.bj;
        bus.out_ready     = ordy;
        flush             = fl;
        #1;
        exp_rdy  = !fl && (sb.size() == 0 || (!sb[0].is_mul && ordy));
        exp_busy = (sb.size() != 0) && sb[0].is_mul;
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        check("busy", 32'(busy), 32'(exp_busy));
        if (s.v && exp_rdy) begin
            e     = model(s);
            e.due = cyc + (e.is_mul ? W + 1 : 1);
            sb.push_back(e);
        end
        flush_prev = fl;
    endtask

    task automatic reset_now();
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        rst_n        = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_branch", 32'(bus.branch), 32'd0);
        check("rst_branch_pc", 32'(bus.branch_pc), 32'd0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        sb.delete();
        flush_prev = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() == 0) begin
                check("out_valid_idle", 32'(bus.out_valid), 32'd0);
            end else if (bus.out_valid) begin
                if (!sb[0].seen) begin
                    check("latency", 32'(cyc), 32'(sb[0].due));
                    sb[0].seen = 1'b1;
                end
                check("result", 32'(bus.result), 32'(sb[0].result));
                check("branch", 32'(bus.branch), 32'(sb[0].branch));
                check("branch_pc", 32'(bus.branch_pc), 32'(sb[0].branch_pc));
                check("illegal", 32'(bus.illegal), 32'(sb[0].illegal));
                if (bus.out_ready) void'(sb.pop_front());
            end else if (!sb[0].seen && cyc > sb[0].due) begin
                total++;
                bad++;
                $display("FAIL timeout: got no out_valid by cycle %0d, required by %0d", cyc, sb[0].due);
                sb[0].seen = 1'b1;
            end
        end
    end

    initial begin
        stim_t s;
        rst_n         = 1'b1;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        s = idle_stim();
        bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.imm = '0;
        bus.seq_pc = '0; bus.use_imm = 1'b0; bus.choose_branch = 1'b0;
        bus.branch_cond = '0; bus.branch_i = 1'b0; bus.branch_j = 1'b0;
        #1;
        reset_now();

        // ADD overflow wraps to 0x8000
        step(mk(3'd0, 16'h7FFF, 16'h0001, '0, '0, 0, 0, 2'd0, 0, 0), 1, 0);
        // signed-negative branch, target from seq_pc
        step(mk(3'd0, 16'hFFFE, 16'h0000, 16'hFFFC, 16'h0010, 0, 0, 2'd2, 1, 0), 1, 0);
        // branch base from a, use_imm operand
        step(mk(3'd5, 16'h1000, 16'h1234, 16'h0020, 16'h0040, 1, 1, 2'd0, 1, 0), 1, 0);
        step(mk(3'd6, 16'h0000, 16'h0000, 16'h0004, 16'h0ABC, 0, 0, 2'd3, 0, 1), 1, 0);
        step(idle_stim(), 1, 0);

        // MUL 0x12*0x34, then idle long enough for the result to retire
        step(mk(3'd7, 16'h0012, 16'h0034, '0, '0, 0, 0, 2'd0, 0, 0), 1, 0);
        for (int unsigned i = 0; i < W + 4; i++) step(idle_stim(), 1, 0);

        // SUB 5-7 held for 5 cycles while upstream keeps offering
        step(mk(3'd1, 16'h0005, 16'h0007, '0, '0, 0, 0, 2'd0, 0, 0), 0, 0);
        for (int unsigned i = 0; i < 5; i++)
            step(mk(3'd2, 16'h00F0, 16'h0F0F, '0, '0, 0, 0, 2'd0, 0, 0), 0, 0);
        step(idle_stim(), 1, 0);
        step(idle_stim(), 1, 0);

        // flush partway through MUL
        step(mk(3'd7, 16'h00FF, 16'h0101, '0, '0, 0, 0, 2'd0, 0, 0), 1, 0);
        for (int unsigned i = 0; i < 7; i++) step(idle_stim(), 1, 0);
        step(idle_stim(), 1, 1);
        for (int unsigned i = 0; i < W + 4; i++) step(idle_stim(), 1, 0);

        // reset partway through MUL
        step(mk(3'd7, 16'h0033, 16'h0011, '0, '0, 0, 0, 2'd0, 0, 0), 1, 0);
        for (int unsigned i = 0; i < 7; i++) step(idle_stim(), 1, 0);
        @(posedge clk);
        #1;
        reset_now();
        for (int unsigned i = 0; i < W + 4; i++) step(idle_stim(), 1, 0);

        // op 111 on its own
        step(mk(3'd7, 16'h0003, 16'h0004, '0, '0, 0, 0, 2'd0, 0, 0), 1, 0);
        step(idle_stim(), 1, 0);

        // random traffic
        for (int unsigned n = 0; n < 3000; n++) begin
            s.v       = ($urandom_range(3) != 0);
            s.op      = 3'($urandom_range(7));
            s.a       = ($urandom_range(7) == 0) ? '0 : W'($urandom);
            s.b       = W'($urandom);
            s.imm     = W'($urandom);
            s.pc      = W'($urandom);
            s.use_imm = $urandom_range(1) != 0;
            s.choose  = $urandom_range(1) != 0;
            s.cond    = 2'($urandom_range(3));
            s.bi      = $urandom_range(1) != 0;
            s.bj      = $urandom_range(3) == 0;
            if ($urandom_range(699) == 0) begin
                @(posedge clk);
                #1;
                reset_now();
            end
            step(s, $urandom_range(3) != 0, $urandom_range(39) == 0);
        end

        for (int unsigned i = 0; i < W + 6; i++) step(idle_stim(), 1, 0);
        check("drain_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute_pipe.md
EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; legal range 8..32.
REQ-002 Port clk input 1: single clock; all state updates on rising edge.
REQ-003 Port rst_n input 1: reset is asynchronous and active-low.
REQ-004 Port flush input 1: synchronous kill of the in-flight and held operation.
REQ-005 Port in_valid input 1: upstream offers an operation.
REQ-006 Port in_ready output 1: stage can accept this cycle.
REQ-007 Port op input 3: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 PASSB, 110 LINK, 111 MUL.
REQ-008 Port a input WIDTH: Rs operand, also branch register base.
REQ-009 Port b input WIDTH: Rt operand.
REQ-010 Port imm input WIDTH: sign-extended immediate.
REQ-011 Port seq_pc input WIDTH: sequential PC.
REQ-012 Port use_imm input 1: B operand = imm instead of b.
REQ-013 Port choose_branch input 1: branch base = a, else seq_pc.
REQ-014 Port branch_cond input 2: 00 a==0, 01 a!=0, 10 a<0 (signed), 11 a>=0.
REQ-015 Port branch_i input 1 / branch_j input 1: conditional / unconditional branch.
REQ-016 Port out_valid output 1 / out_ready input 1: result handshake.
REQ-017 Ports result output WIDTH, branch output 1, branch_pc output WIDTH, illegal output 1, busy output 1.

Function
REQ-018 Transfer occurs when in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
REQ-019 Non-MUL ops: registered outputs valid the cycle after acceptance (latency 1); back-to-back acceptance at full rate.
REQ-020 LINK: result = seq_pc; PASSB: result = B operand; arithmetic modulo 2^WIDTH, carry/overflow discarded.
REQ-021 branch_pc = imm + (choose_branch ? a : seq_pc), modulo 2^WIDTH, captured at acceptance.
REQ-022 branch = (branch_i && cond(branch_cond, a)) || branch_j, captured at acceptance.
REQ-023 States IDLE, MUL, HOLD: IDLE->MUL on MUL accept; MUL->HOLD after WIDTH iterations; HOLD->IDLE when out_ready; busy = (state!=IDLE).
REQ-024 MUL result = low WIDTH bits of a*B (unsigned), out_valid asserted exactly WIDTH+1 cycles after acceptance.
REQ-025 While out_valid && !out_ready, result, branch, branch_pc, illegal SHALL hold stable.
REQ-026 flush: next cycle out_valid=0, state=IDLE, MUL aborted; flush wins over a simultaneous accept or out_ready.
REQ-027 out_ready asserted with out_valid in the same cycle as a new accept: old result retires, new result appears next cycle, no bubble.

Reset
REQ-028 On rst_n low: state=IDLE, out_valid=0, result=0, branch=0, branch_pc=0, illegal=0, busy=0, iteration counter=0.
REQ-029 Reset asserted mid-MUL aborts it; no result is produced after release.

Configuration
REQ-030 Macro EXECUTE_PIPE_MUL_EN defined: MUL as REQ-023/024, sub-module instantiated.
REQ-031 Macro undefined: op 111 completes with latency 1, result=0, illegal=1; MUL state unreachable; multiplier not built.

Structure
REQ-032 Package execute_pkg holds op codes, branch_cond codes, state encoding and default WIDTH.
REQ-033 Sub-module execute_mul_seq: shift-add iterative multiplier, start/done handshake, abort input driven by flush.

Verification
REQ-034 WIDTH=16, ADD a=0x7FFF b=0x0001 -> next cycle out_valid=1, result=0x8000.
REQ-035 branch_i=1, cond=10, a=0xFFFE, choose_branch=0, seq_pc=0x0010, imm=0xFFFC -> branch=1, branch_pc=0x000C.
REQ-036 MUL a=0x0012 b=0x0034 (MUL_EN) -> result=0x03A8 at cycle 17 after accept, in_ready=0 during.
REQ-037 out_ready=0 for 5 cycles after SUB 5-7 -> result=0xFFFE held, in_ready=0 until retirement.
REQ-038 flush at iteration 8 of MUL -> out_valid never rises, in_ready=1 next cycle; repeat with rst_n pulse.
REQ-039 MUL_EN undefined, op=111 -> next cycle illegal=1, result=0.
